vga_pixel_fetch: RTL and testbench

//  Downstream of the VGA timing controller. Consumes pixel_x/pixel_y/video_on/hsync/vsync and

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_sync_delay.sv | 35 +++
 rtl/vga_pixel_fetch.sv | 160 ++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and helpers.
// Holds the 640x480@60 timing constants used by both the timing controller and the
// pixel fetch path, the framebuffer geometry derived from them, the packed control
// bundle that travels alongside the pixel pipeline, and the RGB332 -> 4:4:4 expansion.
package vga_pkg;

    // 640x480 timing, shared with the timing controller
    localparam int H_ACTIVE    = 640;
    localparam int H_FRONT     = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BACK      = 48;
    localparam int H_TOTAL     = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_ACTIVE    = 480;
    localparam int V_FRONT     = 10;
    localparam int V_SYNC      = 2;
    localparam int V_BACK      = 33;
    localparam int V_TOTAL     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Framebuffer geometry at the default 2x downscale
    localparam int SCALE_SHIFT = 1;
    localparam int LINE_W      = H_ACTIVE >> SCALE_SHIFT;
    localparam int FRAME_W     = LINE_W * (V_ACTIVE >> SCALE_SHIFT);

    // Display-enable plus syncs, carried through the latency-matching delay line
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } vga_ctl_t;

    // Blanked, syncs inactive (active-low syncs idle high)
    localparam vga_ctl_t CTL_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1};

    // RGB332 {R[2:0],G[2:0],B[1:0]} to 4:4:4 by bit replication so full scale maps to 4'hF
    function automatic logic [11:0] rgb332_to_444(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register for the pixel control bundle.
// Ports:
//   clk, reset - pixel clock, synchronous active-high reset (all stages to RST_VAL)
//   din        - W-bit bundle entering the pipeline
//   tap        - bundle after DEPTH-1 stages (one clock ahead of dout)
//   dout       - bundle after DEPTH stages
// DEPTH must be at least 2 so the tap exists.
module vga_sync_delay #(
    parameter int             W       = 3,
    parameter int             DEPTH   = 3,
    parameter logic [W-1:0]   RST_VAL = 3'b011
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] tap,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    // The tap feeds the colour register so colour lands in the same cycle as dout
    assign tap  = stage[DEPTH-2];
    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch from a 2x-downscaled, double-buffered RGB332 framebuffer.
// Sits after the VGA timing controller: turns pixel_x/pixel_y into RAM read addresses,
// expands the returned RGB332 to 4:4:4, and delays the syncs so colour and sync align.
// Buffer swaps requested during a frame take effect only at the next frame start.
// Ports:
//   clk, reset            - pixel clock, synchronous active-high reset
//   pixel_x, pixel_y      - current position from the timing controller
//   video_on              - active-area flag from the controller
//   hsync_in, vsync_in    - controller syncs (active low)
//   swap_req              - one-cycle request to show the other buffer from next frame
//   fb_rd_en, fb_rd_addr  - framebuffer RAM read port
//   fb_rd_data            - RAM data, RGB332, valid RD_LATENCY clocks after the address
//   red, green, blue      - 4-bit colour, zero when blanked
//   hsync_out, vsync_out  - syncs delayed by LAT = RD_LATENCY + 2 clocks
//   disp_buf              - buffer currently being scanned out
//   swap_ack              - one-cycle pulse when a swap takes effect
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
    parameter int FB_ADDR_W   = 18,
    parameter int RD_LATENCY  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic                 video_on,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 swap_req,
    output logic                 fb_rd_en,
    output logic [FB_ADDR_W-1:0] fb_rd_addr,
    input  logic [7:0]           fb_rd_data,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 disp_buf,
    output logic                 swap_ack
);

    localparam int LAT       = RD_LATENCY + 2;
    localparam int LINE_PIX  = H_ACTIVE >> SCALE_SHIFT;
    localparam int FRAME_PIX = LINE_PIX * (V_ACTIVE >> SCALE_SHIFT);
    localparam int REP_W     = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'((1 << SCALE_SHIFT) - 1);

    logic                 synced;
    logic                 swap_pend;
    logic [REP_W-1:0]     row_rep;
    logic [FB_ADDR_W-1:0] line_base;

    logic                 in_range;
    logic                 frame_start;
    logic                 line_end;
    logic                 swap_now;
    logic                 disp_buf_next;
    logic                 fetch;
    logic [FB_ADDR_W-1:0] base_now;

    always_comb begin
        in_range      = (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 10'(V_ACTIVE));
        frame_start   = (pixel_x == 10'd0) && (pixel_y == 10'd0);
        line_end      = video_on && in_range && (pixel_x == 10'(H_ACTIVE - 1));
        swap_now      = swap_pend | swap_req;
        disp_buf_next = disp_buf ^ swap_now;
        // At frame start the row base is reloaded this very cycle, so pixel (0,0)
        // must already use the base of the buffer being switched to.
        if (frame_start)
            base_now = disp_buf_next ? FB_ADDR_W'(FRAME_PIX) : '0;
        else
            base_now = line_base;
        // Fetch only once a frame start has been seen, so a mid-frame reset stays blank
        fetch = video_on && in_range && (synced || frame_start);
    end

    // Frame/row tracking and buffer swap
    always_ff @(posedge clk) begin
        if (reset) begin
            synced    <= 1'b0;
            swap_pend <= 1'b0;
            disp_buf  <= 1'b0;
            swap_ack  <= 1'b0;
            row_rep   <= '0;
            line_base <= '0;
        end else begin
            swap_ack <= 1'b0;
            if (frame_start) begin
                synced    <= 1'b1;
                disp_buf  <= disp_buf_next;
                swap_ack  <= swap_now;
                swap_pend <= 1'b0;
                row_rep   <= '0;
                line_base <= base_now;
            end else begin
                if (swap_req) swap_pend <= 1'b1;
                // Each framebuffer row is shown 2**SCALE_SHIFT times before advancing
                if (line_end) begin
                    if (row_rep == REP_LAST) begin
                        row_rep   <= '0;
                        line_base <= line_base + FB_ADDR_W'(LINE_PIX);
                    end else begin
                        row_rep <= row_rep + 1'b1;
                    end
                end
            end
        end
    end

    // ---- stage p0: RAM address ----
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= '0;
        end else begin
            fb_rd_en <= fetch;
            if (fetch) fb_rd_addr <= base_now + FB_ADDR_W'(pixel_x >> SCALE_SHIFT);
        end
    end

    // ---- stages p0..p(LAT-1): control bundle delay ----
    vga_ctl_t   ctl_in;
    logic [2:0] ctl_tap;
    logic [2:0] ctl_out;
    logic       vld_rgb;
    logic [1:0] unused_tap_sync;
    logic       unused_out_de;

    assign ctl_in = '{de: fetch, hsync: hsync_in, vsync: vsync_in};

    vga_sync_delay #(
        .W       (3),
        .DEPTH   (LAT),
        .RST_VAL (CTL_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   (ctl_in),
        .tap   (ctl_tap),
        .dout  (ctl_out)
    );

    assign {vld_rgb, unused_tap_sync}           = ctl_tap;
    assign {unused_out_de, hsync_out, vsync_out} = ctl_out;

    // ---- stage p(LAT-1): colour register, aligned with delayed syncs ----
    always_ff @(posedge clk) begin
        if (reset)
            {red, green, blue} <= '0;
        else if (vld_rgb)
            {red, green, blue} <= rgb332_to_444(fb_rd_data);
        else
            {red, green, blue} <= '0;
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: drives controller coordinates directly (jumping where the
// frame content in between does not matter), models the RAM as returning addr[7:0],
// and runs a RD_LATENCY=1 and a RD_LATENCY=2 instance side by side.
module tb_vga_pixel_fetch;

    localparam int AW = 18;

    logic clk = 1'b0;
    logic reset;
    logic [9:0] pixel_x, pixel_y;
    logic video_on, hsync_in, vsync_in, swap_req;

    logic          rd_en1, rd_en2;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [7:0]    rd_data1, rd_data2, ram2_q1;
    logic [3:0]    r1, g1, b1, r2, g2, b2;
    logic          hs1, vs1, hs2, vs2, buf1, buf2, ack1, ack2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vga_pixel_fetch #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in), .swap_req(swap_req),
        .fb_rd_en(rd_en1), .fb_rd_addr(rd_addr1), .fb_rd_data(rd_data1),
        .red(r1), .green(g1), .blue(b1), .hsync_out(hs1), .vsync_out(vs1),
        .disp_buf(buf1), .swap_ack(ack1)
    );

    vga_pixel_fetch #(.RD_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in), .swap_req(swap_req),
        .fb_rd_en(rd_en2), .fb_rd_addr(rd_addr2), .fb_rd_data(rd_data2),
        .red(r2), .green(g2), .blue(b2), .hsync_out(hs2), .vsync_out(vs2),
        .disp_buf(buf2), .swap_ack(ack2)
    );

    // RAM models: data = addr[7:0], latency 1 and 2
    always @(posedge clk) begin
        if (rd_en1) rd_data1 <= rd_addr1[7:0];
        if (rd_en2) ram2_q1 <= rd_addr2[7:0];
        rd_data2 <= ram2_q1;
    end

    function automatic int rgb1();
        return int'({r1, g1, b1});
    endfunction

    function automatic int rgb2();
        return int'({r2, g2, b2});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input int x, input int y, input bit von = 1'b1, input bit sw = 1'b0,
                        input bit hs = 1'b1, input bit vs = 1'b1);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        swap_req = sw;
        hsync_in = hs;
        vsync_in = vs;
        @(posedge clk);
        #1;
    endtask

    // Four-cycle low pulse on one sync; output must follow 3 (LAT=3) or 4 (LAT=4) clocks later
    task automatic sync_pulse(input bit on_v);
        bit lvl;
        for (int k = 0; k < 8; k++) begin
            lvl = (k > 3);
            step(656, 490, 1'b0, 1'b0, on_v ? 1'b1 : lvl, on_v ? lvl : 1'b1);
            check(on_v ? $sformatf("vsync lat3 k%0d", k) : $sformatf("hsync lat3 k%0d", k),
                  on_v ? int'(vs1) : int'(hs1), (k >= 2 && k <= 5) ? 0 : 1);
            check(on_v ? $sformatf("vsync lat4 k%0d", k) : $sformatf("hsync lat4 k%0d", k),
                  on_v ? int'(vs2) : int'(hs2), (k >= 3 && k <= 6) ? 0 : 1);
        end
    endtask

    typedef struct {
        int x;
        int y;
        int von;
        int en;
        int ca;
        int addr;
        int rgb;
    } vec_t;

    vec_t tbl[22];

    initial begin
        // x, y, video_on | expected fb_rd_en, check addr?, addr, rgb (LAT=3 instance)
        tbl = '{
            '{600, 100, 1, 0, 1,   0, 'h000},
            '{601, 100, 1, 0, 0,   0, 'h000},
            '{639, 100, 1, 0, 0,   0, 'h000},
            '{639, 479, 1, 0, 1,   0, 'h000},
            '{700, 479, 0, 0, 0,   0, 'h000},
            '{  0,   0, 1, 1, 1,   0, 'h000},
            '{  1,   0, 1, 1, 1,   0, 'h000},
            '{  2,   0, 1, 1, 1,   1, 'h000},
            '{  3,   0, 1, 1, 1,   1, 'h000},
            '{  4,   0, 1, 1, 1,   2, 'h005},
            '{  5,   0, 1, 1, 1,   2, 'h005},
            '{330,   0, 1, 1, 1, 165, 'h00A},
            '{510,   0, 1, 1, 1, 255, 'h00A},
            '{639,   0, 1, 1, 1, 319, 'hB25},
            '{700,   0, 0, 0, 1, 319, 'hFFF},
            '{  0,   1, 1, 1, 1,   0, 'h2FF},
            '{639,   1, 1, 1, 1, 319, 'h000},
            '{  0,   2, 1, 1, 1, 320, 'h000},
            '{700,   2, 1, 0, 1, 320, 'h2FF},
            '{  1,   2, 1, 1, 1, 320, 'h400},
            '{  2,   2, 1, 1, 1, 321, 'h000},
            '{  3,   2, 1, 1, 1, 321, 'h400}
        };

        // Reset state
        reset = 1'b1;
        step(600, 100);
        step(600, 100);
        check("reset rgb", rgb1(), 0);
        check("reset hsync", int'(hs1), 1);
        check("reset vsync", int'(vs1), 1);
        check("reset rd_en", int'(rd_en1), 0);
        check("reset addr", int'(rd_addr1), 0);
        check("reset disp_buf", int'(buf1), 0);
        check("reset swap_ack", int'(ack1), 0);
        check("reset hsync lat4", int'(hs2), 1);
        reset = 1'b0;

        // Blank first frame, sync at (0,0), addressing and colour
        foreach (tbl[i]) begin
            step(tbl[i].x, tbl[i].y, tbl[i].von != 0);
            check($sformatf("t%0d rd_en", i), int'(rd_en1), tbl[i].en);
            check($sformatf("t%0d rd_en lat4", i), int'(rd_en2), tbl[i].en);
            if (tbl[i].ca != 0) begin
                check($sformatf("t%0d addr", i), int'(rd_addr1), tbl[i].addr);
                check($sformatf("t%0d addr lat4", i), int'(rd_addr2), tbl[i].addr);
            end
            check($sformatf("t%0d rgb", i), rgb1(), tbl[i].rgb);
        end

        // Line ends down to the last row: (639,479) -> 76799
        for (int y = 2; y < 480; y++) step(639, y);
        check("addr 639,479", int'(rd_addr1), 76799);
        check("addr 639,479 lat4", int'(rd_addr2), 76799);

        // Blanking region: never fetch, colour flushes to zero
        begin
            int bx[8] = '{640, 700, 799,   0, 320, 639, 100, 799};
            int by[8] = '{479, 479, 479, 480, 500, 524, 490, 524};
            bit bv[8] = '{  0,   1,   0,   1,   1,   0,   1,   0};
            for (int i = 0; i < 8; i++) begin
                step(bx[i], by[i], bv[i]);
                check($sformatf("blank%0d rd_en", i), int'(rd_en1), 0);
                if (i >= 2) check($sformatf("blank%0d rgb", i), rgb1(), 0);
                if (i >= 3) check($sformatf("blank%0d rgb lat4", i), rgb2(), 0);
            end
        end

        // Sync latency
        sync_pulse(1'b0);
        sync_pulse(1'b1);

        // Mid-frame swap requests collapse into one swap at frame start
        step(100, 100, 1'b1, 1'b1);
        check("swap mid buf", int'(buf1), 0);
        check("swap mid ack", int'(ack1), 0);
        step(101, 100);
        step(200, 150, 1'b1, 1'b1);
        check("swap mid2 buf", int'(buf1), 0);
        step(639, 479, 1'b1, 1'b1);
        check("swap mid3 buf", int'(buf1), 0);
        check("swap mid3 ack", int'(ack1), 0);
        step(700, 500, 1'b0);
        step(0, 0);
        check("swap fs buf", int'(buf1), 1);
        check("swap fs ack", int'(ack1), 1);
        check("swap fs ack lat4", int'(ack2), 1);
        check("swap fs addr", int'(rd_addr1), 76800);
        step(1, 0);
        check("swap fs+1 ack", int'(ack1), 0);
        check("swap fs+1 buf", int'(buf1), 1);
        check("swap fs+1 addr", int'(rd_addr1), 76800);
        step(2, 0);
        check("swap fs+2 addr", int'(rd_addr1), 76801);
        step(639, 479);
        step(0, 0);
        check("noswap fs buf", int'(buf1), 1);
        check("noswap fs ack", int'(ack1), 0);
        check("noswap fs addr", int'(rd_addr1), 76800);

        // Reset mid-frame at (300,200): blank until next frame start
        step(298, 200);
        step(299, 200);
        reset = 1'b1;
        step(300, 200);
        step(301, 200);
        reset = 1'b0;
        check("midrst rgb", rgb1(), 0);
        check("midrst rd_en", int'(rd_en1), 0);
        check("midrst buf", int'(buf1), 0);
        for (int x = 302; x < 306; x++) begin
            step(x, 200);
            check($sformatf("midrst x%0d rd_en", x), int'(rd_en1), 0);
            check($sformatf("midrst x%0d rgb", x), rgb1(), 0);
        end
        step(639, 479);
        check("midrst eof rd_en", int'(rd_en1), 0);
        step(700, 500, 1'b0);
        for (int x = 0; x < 8; x++) begin
            step(x, 0);
            if (x == 0) begin
                check("resume rd_en", int'(rd_en1), 1);
                check("resume addr", int'(rd_addr1), 0);
                check("resume buf", int'(buf1), 0);
                check("resume ack", int'(ack1), 0);
            end
            if (x == 6) begin
                check("resume rgb x4", rgb1(), 'h00A);
                check("resume rgb lat4 x3", rgb2(), 'h005);
            end
            if (x == 7) begin
                check("resume rgb x5", rgb1(), 'h00A);
                check("resume rgb lat4 x4", rgb2(), 'h00A);
            end
        end

        // Swap request in the frame-start cycle itself
        step(10, 10);
        step(0, 0, 1'b1, 1'b1);
        check("fsreq buf", int'(buf1), 1);
        check("fsreq buf lat4", int'(buf2), 1);
        check("fsreq ack", int'(ack1), 1);
        check("fsreq addr", int'(rd_addr1), 76800);
        check("fsreq addr lat4", int'(rd_addr2), 76800);
        step(1, 0);
        check("fsreq+1 ack", int'(ack1), 0);
        check("fsreq+1 buf", int'(buf1), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
